// File: rtl/dm_ahb_write_buffer_if.sv
// AHB bus signal bundle for the data-memory write buffer (master side = buffer).
interface dm_ahb_write_buffer_if;
  logic        HBUSREQ;
  logic        HLOCK;
  logic        HGRANT;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  modport master (
    output HBUSREQ, HLOCK, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HGRANT, HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HBUSREQ, HLOCK, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HGRANT, HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/dm_ahb_write_buffer.sv
// Data-memory AHB master: posts CPU stores into a FIFO, drains them as single writes, loads go behind stores.
// Optional macro WB_FWD_EN: loads hitting a buffered store are answered from the buffer without a bus access.
module dm_ahb_write_buffer #(
  parameter int WB_DEPTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  bus_err,
  dm_ahb_write_buffer_if.master ahb
);

  localparam int AW = $clog2(WB_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, ADDR, DATA} state_t;

  state_t        state, state_nxt;
  logic          op_load, op_load_nxt;
  logic [31:0]   addr_mem [WB_DEPTH];
  logic [31:0]   data_mem [WB_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full, empty, push, pop, data_done, resp_err;
  logic          load_done, load_pend, fwd_take, fwd_hit, err_q;
  logic [31:0]   fwd_data, rdata_q;

  assign full      = (count == CW'(WB_DEPTH));
  assign empty     = (count == '0);
  assign push      = cpu_req & cpu_write & ~full & HRESETn;
  assign data_done = (state == DATA) & ahb.HREADY;
  assign pop       = data_done & ~op_load;
  assign resp_err  = (ahb.HRESP == 2'b01);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign fwd_take  = cpu_req & ~cpu_write & ~load_done & fwd_hit;
  // load_done masks the cycle where the finished load is still presented
  assign load_pend = cpu_req & ~cpu_write & ~load_done & ~fwd_hit;

`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest matching store wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      fwd_idx = rd_ptr + AW'(k);
      if ((CW'(k) < count) && (addr_mem[fwd_idx] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= IDLE;
      op_load <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_load <= op_load_nxt;
    end
  end

  // Stores always win over a waiting load; every transfer re-arbitrates through REQ
  always_comb begin
    state_nxt   = state;
    op_load_nxt = op_load;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt   = REQ;
          op_load_nxt = 1'b0;
        end else if (load_pend) begin
          state_nxt   = REQ;
          op_load_nxt = 1'b1;
        end
      end
      REQ: begin
        if (ahb.HGRANT && ahb.HREADY) state_nxt = ADDR;
      end
      ADDR: begin
        if (ahb.HREADY)       state_nxt = DATA;
        else if (!ahb.HGRANT) state_nxt = REQ;
      end
      DATA: begin
        if (ahb.HREADY) begin
          if (count_nxt != '0) begin
            state_nxt   = REQ;
            op_load_nxt = 1'b0;
          end else if (load_pend && !op_load) begin
            state_nxt   = REQ;
            op_load_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      addr_mem[wr_ptr] <= cpu_addr;
      data_mem[wr_ptr] <= cpu_wdata;
    end
  end

  // An errored load returns zero rather than whatever the slave left on HRDATA
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      load_done <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      load_done <= (data_done & op_load) | fwd_take;
      err_q     <= data_done & resp_err;
      if (data_done && op_load) rdata_q <= resp_err ? 32'h0 : ahb.HRDATA;
      else if (fwd_take)        rdata_q <= fwd_data;
    end
  end

  assign cpu_ready = push | load_done;
  assign cpu_rdata = rdata_q;
  assign bus_err   = err_q;

  assign ahb.HBUSREQ = (state != IDLE);
  assign ahb.HLOCK   = 1'b0;
  assign ahb.HSIZE   = 3'b010;
  assign ahb.HTRANS  = (state == ADDR) ? 2'b10 : 2'b00;
  assign ahb.HWRITE  = (state == ADDR) & ~op_load;
  assign ahb.HADDR   = (state != ADDR) ? 32'h0 : (op_load ? cpu_addr : addr_mem[rd_ptr]);
  assign ahb.HWDATA  = ((state == DATA) && !op_load) ? data_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_dm_ahb_write_buffer.sv
// Scoreboard bench for dm_ahb_write_buffer: CPU driver, AHB slave responder and monitor run as separate processes.
// Builds with or without WB_FWD_EN; the forwarding scenario only runs when the macro is defined.
module tb_dm_ahb_write_buffer;

  localparam logic [31:0] ERR_ADDR = 32'h0000_0EEC;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          write;
    bit          err;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cpu_req, cpu_write, cpu_ready, bus_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;

  dm_ahb_write_buffer_if ahb ();

  dm_ahb_write_buffer #(.WB_DEPTH(4)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cpu_req   (cpu_req),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .bus_err   (bus_err),
    .ahb       (ahb)
  );

  always #5 HCLK = ~HCLK;

  xfer_t       exp_bus[$];
  xfer_t       exp_load[$];
  xfer_t       obs_bus[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  int          checks = 0;
  int          passes = 0;
  int          exp_errs = 0;
  int          err_seen = 0;
  bit          stall = 1'b0;
  int          ready_pct = 100;
  int          grant_pct = 100;

  function automatic logic [31:0] dflt(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] slv_read(logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    if (a == ERR_ADDR) return 32'h0;
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // One CPU access; returns the number of stall cycles before cpu_ready
  task automatic apply_stimulus(bit wr, logic [31:0] a, logic [31:0] d, output int waits);
    cpu_req   = 1'b1;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = wr ? d : $urandom;
    waits     = 0;
    if (a == ERR_ADDR) exp_errs++;
    if (wr) begin
      exp_bus.push_back('{addr: a, data: d, write: 1'b1, err: (a == ERR_ADDR)});
      if (a != ERR_ADDR) ref_mem[a] = d;
    end else begin
      exp_load.push_back('{addr: a, data: d, write: 1'b0, err: 1'b0});
    end
    forever begin
      #1;
      if (cpu_ready) break;
      waits++;
      if (waits > 200) begin
        check_output("cpu_ready_timeout", 32'(waits), 32'd0);
        break;
      end
      @(negedge HCLK);
    end
    @(negedge HCLK);
    cpu_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_bus.size() != 0 || exp_load.size() != 0) && n < 400) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 400) check_output("drain_timeout", 32'(exp_bus.size() + exp_load.size()), 32'd0);
    repeat (3) @(negedge HCLK);
  endtask

  task automatic check_reset_outputs(string tag);
    #1;
    check_output({tag, "_hbusreq"}, 32'(ahb.HBUSREQ), 32'd0);
    check_output({tag, "_htrans"},  32'(ahb.HTRANS),  32'd0);
    check_output({tag, "_haddr"},   ahb.HADDR,        32'd0);
    check_output({tag, "_hwrite"},  32'(ahb.HWRITE),  32'd0);
    check_output({tag, "_hwdata"},  ahb.HWDATA,       32'd0);
    check_output({tag, "_rdata"},   cpu_rdata,        32'd0);
    check_output({tag, "_ready"},   32'(cpu_ready),   32'd0);
    check_output({tag, "_bus_err"}, 32'(bus_err),     32'd0);
    @(negedge HCLK);
  endtask

  // AHB slave: drives responses at negedge, records each completed data phase for the monitor
  initial begin : slave
    bit          dph = 1'b0;
    bit          dph_wr = 1'b0;
    logic [31:0] dph_addr = '0;
    bit          rdy;
    ahb.HREADY = 1'b1;
    ahb.HGRANT = 1'b0;
    ahb.HRESP  = 2'b00;
    ahb.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      rdy        = stall ? 1'b0 : ($urandom_range(99) < ready_pct);
      ahb.HREADY = rdy;
      ahb.HGRANT = ($urandom_range(99) < grant_pct);
      if (dph && rdy && dph_addr == ERR_ADDR) ahb.HRESP = 2'b01;
      else ahb.HRESP = ($urandom_range(2) == 0) ? 2'b00 : {1'b1, 1'($urandom_range(1))};
      ahb.HRDATA = (dph && !dph_wr) ? slv_read(dph_addr) : $urandom;
      #1;
      if (!HRESETn) begin
        dph = 1'b0;
      end else begin
        if (dph && rdy) begin
          obs_bus.push_back('{addr: dph_addr, data: dph_wr ? ahb.HWDATA : ahb.HRDATA,
                              write: dph_wr, err: (ahb.HRESP == 2'b01)});
          if (dph_wr && ahb.HRESP != 2'b01) slv_mem[dph_addr] = ahb.HWDATA;
          dph = 1'b0;
        end
        if (ahb.HTRANS == 2'b10 && rdy) begin
          dph      = 1'b1;
          dph_addr = ahb.HADDR;
          dph_wr   = ahb.HWRITE;
        end
      end
    end
  end

  // Monitor: pops the expectation queues whenever the bus or the CPU port shows a completion
  initial begin : monitor
    bit    exp_err_next = 1'b0;
    xfer_t o, e;
    forever begin
      @(negedge HCLK);
      #2;
      if (!HRESETn) begin
        obs_bus.delete();
        exp_err_next = 1'b0;
        continue;
      end
      if (exp_err_next || bus_err) check_output("bus_err_pulse", 32'(bus_err), 32'(exp_err_next));
      exp_err_next = 1'b0;
      while (obs_bus.size() != 0) begin
        o = obs_bus.pop_front();
        if (o.err) begin
          exp_err_next = 1'b1;
          err_seen++;
        end
        if (o.write) begin
          check_output("write_expected", 32'(exp_bus.size() != 0), 32'd1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check_output("write_addr", o.addr, e.addr);
            check_output("write_data", o.data, e.data);
            check_output("write_err",  32'(o.err), 32'(e.err));
          end
        end else begin
          check_output("read_order", 32'(exp_bus.size()), 32'd0);
          check_output("read_expected", 32'(exp_load.size() != 0), 32'd1);
          if (exp_load.size() != 0) check_output("read_addr", o.addr, exp_load[0].addr);
        end
      end
      if (cpu_req && !cpu_write && cpu_ready) begin
        check_output("load_expected", 32'(exp_load.size() != 0), 32'd1);
        if (exp_load.size() != 0) begin
          e = exp_load.pop_front();
          check_output("load_data", cpu_rdata, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    int          w;
    logic [31:0] a;
    cpu_req   = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    HRESETn   = 1'b0;
    repeat (2) @(negedge HCLK);
    check_reset_outputs("por");
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Reset while a write sits on the bus
    stall = 1'b1;
    apply_stimulus(1'b1, 32'h80, 32'h1, w);
    apply_stimulus(1'b1, 32'h84, 32'h2, w);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    check_reset_outputs("rst");
    exp_bus.delete();
    HRESETn = 1'b1;
    stall   = 1'b0;
    @(negedge HCLK);
    #1;
    check_output("post_reset_idle", 32'(ahb.HBUSREQ), 32'd0);
    @(negedge HCLK);

    // Back-to-back stores complete with no wait
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), w);
      check_output("store_nowait", 32'(w), 32'd0);
    end
    wait_drain();

    // Fifth store against a full buffer with the bus stalled
    stall = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h110 + 32'(4 * i), 32'hB0 + 32'(i), w);
    fork
      begin
        repeat (6) @(negedge HCLK);
        stall = 1'b0;
      end
    join_none
    apply_stimulus(1'b1, 32'h120, 32'hB4, w);
    check_output("full_stall", 32'(w >= 6 && w <= 15), 32'd1);
    wait_drain();

    // Store then load: write must reach the bus first
    slv_mem[32'h300] = 32'h77;
    apply_stimulus(1'b1, 32'h200, 32'h55, w);
    apply_stimulus(1'b0, 32'h300, 32'h77, w);
    wait_drain();
    slv_mem[32'h304] = 32'h1234;
    apply_stimulus(1'b0, 32'h304, 32'h1234, w);
    check_output("load_latency", 32'(w), 32'd4);
    wait_drain();

    // Error responses on a load and a store, then a normal store
    apply_stimulus(1'b0, ERR_ADDR, 32'h0, w);
    apply_stimulus(1'b1, ERR_ADDR, 32'hBAD, w);
    apply_stimulus(1'b1, 32'h208, 32'h66, w);
    wait_drain();

`ifdef WB_FWD_EN
    grant_pct = 0;
    apply_stimulus(1'b1, 32'h40, 32'h11, w);
    apply_stimulus(1'b1, 32'h40, 32'h22, w);
    apply_stimulus(1'b0, 32'h40, 32'h22, w);
    check_output("fwd_latency", 32'(w), 32'd1);
    grant_pct = 100;
    wait_drain();
`endif

    // Randomised traffic over a small address window
    ready_pct = 70;
    grant_pct = 80;
    for (int n = 0; n < 300; n++) begin
      a = 32'h1000 + 32'(4 * $urandom_range(7));
      if ($urandom_range(99) < 60) apply_stimulus(1'b1, a, $urandom, w);
      else apply_stimulus(1'b0, a, ref_read(a), w);
      if ($urandom_range(3) == 0) repeat ($urandom_range(2)) @(negedge HCLK);
    end
    ready_pct = 100;
    grant_pct = 100;
    wait_drain();
    repeat (3) @(negedge HCLK);
    check_output("err_count", 32'(err_seen), 32'(exp_errs));
    check_output("queues_empty", 32'(exp_bus.size() + exp_load.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
